// File: rtl/control_sequencer_pkg.sv
// Shared CPU definitions: machine-state encodings and the stop-instruction prefix,
// used by the sequencer and the instruction decoder.
package control_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b10,
    ST_EXEC2 = 2'b01,
    ST_HALT  = 2'b11
  } seq_state_t;

  localparam logic [11:0] STP_OPCODE_PREFIX = 12'hF01;

  function automatic logic is_stp(input logic [15:0] instr, input logic [11:0] prefix);
    return instr[15:4] == prefix;
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Instruction sequencer: owns the machine state and instruction register, handles
// memory stalls, stop-instruction halt, single-step and the retired-instruction count.
//
// state | meaning
// FETCH | latch ram_q into IR when memory is ready
// EXEC1 | first execute cycle; retire unless the decoder asks for EXEC2
// EXEC2 | second execute cycle of a two-cycle instruction; always retires
// HALT  | stopped after STP or single-step; waits for run
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter logic [15:0] IR_RESET   = 16'h0000,
  parameter logic [11:0] STP_PREFIX = STP_OPCODE_PREFIX,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          ram_q,
  input  logic                 sm_extra,
  input  logic                 stall,
  input  logic                 run,
  input  logic                 step_mode,
  output logic [1:0]           state,
  output logic [15:0]          instruction,
  output logic                 halted,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] retired
);

  seq_state_t  st;
  logic [15:0] ir;
  logic        retire;

  // Retire happens on the edge leaving EXEC1 without an EXEC2 request, or leaving EXEC2.
  assign retire = !stall && ((st == ST_EXEC1 && !sm_extra) || (st == ST_EXEC2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_FETCH;
      ir      <= IR_RESET;
      retired <= '0;
    end else begin
      case (st)
        ST_FETCH: begin
          if (!stall) begin
            ir <= ram_q;
            st <= ST_EXEC1;
          end
        end
        ST_EXEC1: begin
          if (!stall) begin
            if (sm_extra)                  st <= ST_EXEC2;
            else if (is_stp(ir, STP_PREFIX)) st <= ST_HALT;
            else                           st <= step_mode ? ST_HALT : ST_FETCH;
          end
        end
        ST_EXEC2: begin
          if (!stall) st <= step_mode ? ST_HALT : ST_FETCH;
        end
        ST_HALT: begin
          if (run) st <= ST_FETCH;
        end
        default: st <= ST_FETCH;
      endcase
      if (retire) retired <= retired + CNT_WIDTH'(1);
    end
  end

  assign state       = st;
  assign instruction = ir;
  assign halted      = (st == ST_HALT);
  assign instr_done  = retire;

endmodule
